// File: rtl/keypad4x4_scanner.sv
// 4x4 matrix keypad scanner: walks a low column across the keypad, debounces
// a single-row press, encodes it as {row,col} and shifts it into a 32-bit
// history word with a sticky valid flag cleared by a CPU read strobe.
module keypad4x4_scanner #(
    parameter int SCAN_DIV       = 15,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic [3:0]  i_row,
    output logic [3:0]  o_col,
    output logic [3:0]  o_key,
    output logic        o_valid,
    output logic [31:0] o_data
);

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD
    } state_t;

    localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_SCANS);

    logic [SCAN_DIV-1:0] cnt_q;
    logic                tick;
    logic [3:0]          rowMeta_q;
    logic [3:0]          rowSync_q;

    state_t      state_q, state_d;
    logic [1:0]  col_q, col_d;
    logic [1:0]  rowIdx_q, rowIdx_d;
    logic [3:0]  dbCnt_q, dbCnt_d;
    logic [3:0]  key_q, key_d;
    logic        valid_q, valid_d;
    logic [31:0] data_q, data_d;

    logic        oneLow;
    logic [1:0]  lowIdx;
    logic        allHigh;
    logic        accept;
    logic [3:0]  code;

    assign tick    = &cnt_q;
    assign allHigh = (rowSync_q == 4'hF);
    assign code    = {rowIdx_q, col_q};

    // Free-running prescaler; the all-ones state is the scan enable.
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_q + 1'b1;
    end

    // Two-flop synchronizer for the asynchronous row inputs, idling high.
    always_ff @(posedge clk) begin
        if (reset) begin
            rowMeta_q <= 4'hF;
            rowSync_q <= 4'hF;
        end else begin
            rowMeta_q <= i_row;
            rowSync_q <= rowMeta_q;
        end
    end

    // A sample is a usable key only when exactly one row is pulled low.
    always_comb begin
        oneLow = 1'b0;
        lowIdx = 2'd0;
        case (rowSync_q)
            4'b1110: begin oneLow = 1'b1; lowIdx = 2'd0; end
            4'b1101: begin oneLow = 1'b1; lowIdx = 2'd1; end
            4'b1011: begin oneLow = 1'b1; lowIdx = 2'd2; end
            4'b0111: begin oneLow = 1'b1; lowIdx = 2'd3; end
            default: begin oneLow = 1'b0; lowIdx = 2'd0; end
        endcase
    end

    // Scan/debounce/hold sequencing plus the accept side effects on the history.
    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        rowIdx_d = rowIdx_q;
        dbCnt_d  = dbCnt_q;
        accept   = 1'b0;
        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (oneLow) begin
                        rowIdx_d = lowIdx;
                        dbCnt_d  = 4'd1;
                        state_d  = DEBOUNCE;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (oneLow && (lowIdx == rowIdx_q)) begin
                        if (dbCnt_q + 4'd1 == DB_LAST) begin
                            accept  = 1'b1;
                            dbCnt_d = 4'd0;
                            state_d = HELD;
                        end else begin
                            dbCnt_d = dbCnt_q + 4'd1;
                        end
                    end else begin
                        dbCnt_d = 4'd0;
                        col_d   = col_q + 2'd1;
                        state_d = SCAN;
                    end
                end
                HELD: begin
                    if (allHigh) begin
                        if (dbCnt_q + 4'd1 == DB_LAST) begin
                            dbCnt_d = 4'd0;
                            col_d   = col_q + 2'd1;
                            state_d = SCAN;
                        end else begin
                            dbCnt_d = dbCnt_q + 4'd1;
                        end
                    end else begin
                        dbCnt_d = 4'd0;
                    end
                end
                default: begin
                    dbCnt_d = 4'd0;
                    state_d = SCAN;
                end
            endcase
        end
        key_d   = accept ? code : key_q;
        data_d  = accept ? {data_q[27:0], code} : data_q;
        valid_d = accept ? 1'b1 : (cs ? 1'b0 : valid_q);
    end

    // State and output registers; an accept outranks a simultaneous read strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= SCAN;
            col_q    <= 2'd0;
            rowIdx_q <= 2'd0;
            dbCnt_q  <= 4'd0;
            key_q    <= 4'd0;
            valid_q  <= 1'b0;
            data_q   <= 32'd0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            rowIdx_q <= rowIdx_d;
            dbCnt_q  <= dbCnt_d;
            key_q    <= key_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
        end
    end

    assign o_col   = ~(4'b0001 << col_q);
    assign o_key   = key_q;
    assign o_valid = valid_q;
    assign o_data  = data_q;

endmodule

// File: doc/keypad4x4_scanner.md
Name: keypad4x4_scanner

Overview:
- Input-side counterpart of the scanned 7-segment display driver: scans a 4x4 matrix keypad by driving columns low one at a time and reading the rows.
- Debounces each press and encodes it to a 4-bit hex code.
- Shifts codes into a 32-bit history word the CPU reads through a chip-select handshake; the history word can be routed straight to the display driver.

Parameters:
- SCAN_DIV, 15, prescaler width; scan tick fires once every 2^SCAN_DIV clocks.
- DEBOUNCE_SCANS, 4, consecutive identical scan samples needed to accept a press or confirm a release (range 2..15).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- cs  input  1  CPU read acknowledge; clears o_valid.
- i_row  input  4  keypad rows, active-low, asynchronous.
- o_col  output  4  column drive, active-low one-cold.
- o_key  output  4  code of the most recent accepted key.
- o_valid  output  1  sticky flag: new key since last cs.
- o_data  output  32  last eight key codes, newest in [3:0].

Behaviour:
- Clocking: one clock; reset is synchronous and active-high. The prescaler counter `cnt` produces a one-clk `tick` when cnt is all ones. `tick` is an enable, never a derived clock.
- Synchronizer: i_row passes through two flops reset to 4'hF. The FSM sees row changes 2 clks late.
- Reset values: o_col=4'b1110, o_key=0, o_valid=0, o_data=0, cnt=0, column index=0, state=SCAN, debounce count=0.
- Column drive: column index c drives o_col = ~(1<<c). Row samples are taken only on tick.
- Valid row sample: exactly one synced row bit low. Zero low or two or more low counts as "no key".
- Key code: code = {row_index[1:0], col_index[1:0]}.
- FSM state SCAN, per tick:
  - Valid row sample: latch row index, freeze column, set count=1, go DEBOUNCE.
  - Otherwise: column index increments mod 4 (3 wraps to 0).
- FSM state DEBOUNCE, per tick:
  - Same single row low: count+1. When count reaches DEBOUNCE_SCANS, accept the key and go HELD.
  - Any other sample: go SCAN, count=0, column advances.
- Key accept (same clk edge as the accepting tick):
  - o_key<=code.
  - o_data<={o_data[27:0],code}; the oldest nibble is dropped.
  - o_valid<=1.
- Accept latency: DEBOUNCE_SCANS-1 ticks after the detecting tick.
- FSM state HELD:
  - Column stays frozen and no further accepts occur (no auto-repeat).
  - Each tick with all rows high increments the release count; any row low resets it to 0.
  - At DEBOUNCE_SCANS, go SCAN and advance the column.
- Handshake: cs high on a clk edge clears o_valid. If an accept happens on the same edge, the accept wins and o_valid=1.
- o_key and o_data are stable between accepts; cs does not modify them.
- Reset mid-operation: any state returns to SCAN with the reset values above. A key still held after reset is re-detected as a new press.

Test Plan (SCAN_DIV=3, DEBOUNCE_SCANS=4):
1. Reset: assert reset 3 clks -> o_col=4'b1110, o_key=0, o_valid=0, o_data=0. Release reset -> o_col steps 1110,1101,1011,0111,1110 on successive ticks (every 8 clks).
2. Held press:
   - Stimulus: pull row2 low whenever o_col=4'b1101, held 12 ticks, then released.
   - While held: one accept only, o_key=4'h9, o_data=32'h00000009, o_valid=1. o_col held at 1101 until 4 all-high ticks after release, then advances to 1011.
3. Bounce: row0 low with col0 for 2 ticks, then high -> no accept; o_valid=0, o_data unchanged, scan resumes.
4. History wrap: accept codes 1,2,3,4,5,6,7,8, then F -> o_data=32'h2345678F, o_key=4'hF.
5. Handshake:
   - cs pulse one clk after an accept -> o_valid=0 next edge, o_data unchanged.
   - cs asserted on the exact accept edge -> o_valid stays 1.
6. Rejects and reset:
   - Rows 1 and 3 both low at col2 -> no accept, scanning continues.
   - Reset asserted during DEBOUNCE -> next edge state=SCAN, o_col=4'b1110, o_valid=0.
